multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 113 +++++++++++
 tb/tb_multi_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: NCH independent interval timers sharing only the clock.
// Each channel counts from 0 up to its captured terminal count, emits a
// one-cycle PULSE on expiry, and latches a sticky PEND flag that software
// clears with CLR. Channels are one-shot or periodic, chosen at START.

module multi_timer_ch #(
  parameter int WIDTH = 21
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] tc,
  input  logic             clr,
  output logic             pulse,
  output logic             busy,
  output logic             pend
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] tc_q;
  logic             per_q;
  logic             hit;

  // Terminal reached: only meaningful while counting.
  assign hit = (state == COUNT) && (cnt == tc_q);

  // Channel FSM; priority is reset > STOP > START/retrigger > terminal.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      tc_q  <= '0;
      per_q <= 1'b0;
      pulse <= 1'b0;
      busy  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      busy  <= 1'b0;
    end else if (start) begin
      // Capture mode/limit only here so later input changes are ignored.
      state <= COUNT;
      cnt   <= '0;
      tc_q  <= tc;
      per_q <= periodic;
      pulse <= 1'b0;
      busy  <= 1'b1;
    end else if (hit) begin
      cnt   <= '0;
      pulse <= 1'b1;
      if (!per_q) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      pulse <= 1'b0;
      if (state == COUNT) cnt <= cnt + 1'b1;
    end
  end

  // Sticky expiry flag; a new expiry beats a coincident clear.
  always_ff @(posedge CLK) begin
    if (!RST_N)                         pend <= 1'b0;
    else if (hit && !stop && !start)    pend <= 1'b1;
    else if (clr)                       pend <= 1'b0;
  end

endmodule

module multi_timer #(
  parameter int NCH   = 4,
  parameter int WIDTH = 21
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NCH-1:0]       START,
  input  logic [NCH-1:0]       STOP,
  input  logic [NCH-1:0]       PERIODIC,
  input  logic [NCH*WIDTH-1:0] TC,
  input  logic [NCH-1:0]       CLR,
  output logic [NCH-1:0]       PULSE,
  output logic [NCH-1:0]       BUSY,
  output logic [NCH-1:0]       PEND,
  output logic                 ANY_PEND
);

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      multi_timer_ch #(.WIDTH(WIDTH)) u_ch (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (START[i]),
        .stop     (STOP[i]),
        .periodic (PERIODIC[i]),
        .tc       (TC[i*WIDTH +: WIDTH]),
        .clr      (CLR[i]),
        .pulse    (PULSE[i]),
        .busy     (BUSY[i]),
        .pend     (PEND[i])
      );
    end
  endgenerate

  assign ANY_PEND = |PEND;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an absolute-time model
// (each active channel remembers the edge number at which it must fire next).

module tb_multi_timer;
  localparam int NCH   = 4;
  localparam int WIDTH = 21;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [NCH-1:0]       START, STOP, PERIODIC, CLR;
  logic [NCH*WIDTH-1:0] TC;
  logic [NCH-1:0]       PULSE, BUSY, PEND;
  logic                 ANY_PEND;

  multi_timer #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
    .PERIODIC(PERIODIC), .TC(TC), .CLR(CLR),
    .PULSE(PULSE), .BUSY(BUSY), .PEND(PEND), .ANY_PEND(ANY_PEND)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  longint         cyc = 0;
  bit             m_ok = 0;
  bit [NCH-1:0]   m_act, m_per, m_pulse, m_pend;
  longint         m_tc   [NCH];
  longint         m_fire [NCH];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST_N) begin
      m_act   <= '0;
      m_pulse <= '0;
      m_pend  <= '0;
      m_ok    <= 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        automatic bit     act  = m_act[c];
        automatic bit     per  = m_per[c];
        automatic bit     pl   = 1'b0;
        automatic bit     pd   = m_pend[c];
        automatic longint tcv  = m_tc[c];
        automatic longint fire = m_fire[c];
        if (STOP[c]) act = 1'b0;
        else if (START[c]) begin
          act  = 1'b1;
          tcv  = longint'(TC[c*WIDTH +: WIDTH]);
          per  = PERIODIC[c];
          fire = cyc + tcv + 1;
        end else if (act && cyc == fire) begin
          pl = 1'b1;
          if (per) fire = cyc + tcv + 1;
          else     act  = 1'b0;
        end
        if (pl)          pd = 1'b1;
        else if (CLR[c]) pd = 1'b0;
        m_act[c]   <= act;
        m_per[c]   <= per;
        m_pulse[c] <= pl;
        m_pend[c]  <= pd;
        m_tc[c]    <= tcv;
        m_fire[c]  <= fire;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (m_ok) begin
      chk("pulse", 64'(PULSE), 64'(m_pulse));
      chk("busy",  64'(BUSY),  64'(m_act));
      chk("pend",  64'(PEND),  64'(m_pend));
      chk("any_pend", 64'(ANY_PEND), 64'(|m_pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic set_tc(input int c, input int v);
    TC[c*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  initial begin
    bit saw;
    RST_N = 1'b0; START = '0; STOP = '0; PERIODIC = '0; CLR = '0; TC = '0;
    START = '1; STOP = '1;   // reset must win over everything
    repeat (3) tick();
    START = '0; STOP = '0;
    chk("rst_busy", 64'(BUSY), 64'h0);
    chk("rst_pulse", 64'(PULSE), 64'h0);
    chk("rst_pend", 64'(PEND), 64'h0);
    chk("rst_any", 64'(ANY_PEND), 64'h0);

    // ch0 TC=5 one-shot, started on the first edge out of reset
    RST_N = 1'b1;
    START[0] = 1'b1; set_tc(0, 5);
    tick();
    START[0] = 1'b0; set_tc(0, 1);   // must not affect the running count
    chk("a_busy_start", 64'(BUSY[0]), 64'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("a_pulse_early", 64'(PULSE[0]), 64'h0);
      chk("a_busy_run", 64'(BUSY[0]), 64'h1);
    end
    tick();
    chk("a_pulse", 64'(PULSE[0]), 64'h1);
    chk("a_busy_end", 64'(BUSY[0]), 64'h0);
    chk("a_pend", 64'(PEND[0]), 64'h1);
    chk("a_any", 64'(ANY_PEND), 64'h1);
    tick();
    chk("a_pulse_once", 64'(PULSE[0]), 64'h0);

    // ch1 TC=3 periodic, stopped at edge 13
    START[1] = 1'b1; PERIODIC[1] = 1'b1; set_tc(1, 3);
    tick();
    START[1] = 1'b0; PERIODIC[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("b_pulse", 64'(PULSE[1]), (e % 4 == 0) ? 64'h1 : 64'h0);
      chk("b_busy", 64'(BUSY[1]), 64'h1);
    end
    STOP[1] = 1'b1;
    tick();
    STOP[1] = 1'b0;
    chk("b_stop_busy", 64'(BUSY[1]), 64'h0);
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("b_no_pulse", 64'(PULSE[1]), 64'h0);
    end

    // ch2 TC=4, retriggered at edge 3 with TC=2 -> fires at edge 6 only
    START[2] = 1'b1; set_tc(2, 4);
    tick();
    START[2] = 1'b0;
    tick(); tick();
    START[2] = 1'b1; set_tc(2, 2);
    tick();
    START[2] = 1'b0;
    chk("c_pulse3", 64'(PULSE[2]), 64'h0);
    tick(); chk("c_pulse4", 64'(PULSE[2]), 64'h0);
    tick(); chk("c_pulse5", 64'(PULSE[2]), 64'h0);
    tick(); chk("c_pulse6", 64'(PULSE[2]), 64'h1);
    tick(); chk("c_pulse7", 64'(PULSE[2]), 64'h0);

    // ch3: START+STOP in IDLE stays idle; STOP on the terminal edge suppresses expiry
    START[3] = 1'b1; STOP[3] = 1'b1; set_tc(3, 2);
    tick();
    STOP[3] = 1'b0;
    chk("d_idle", 64'(BUSY[3]), 64'h0);
    tick();
    START[3] = 1'b0;
    tick(); tick();
    STOP[3] = 1'b1;
    tick();
    STOP[3] = 1'b0;
    chk("d_stop_pulse", 64'(PULSE[3]), 64'h0);
    chk("d_stop_busy", 64'(BUSY[3]), 64'h0);
    chk("d_stop_pend", 64'(PEND[3]), 64'h0);

    // set vs clear priority on PEND
    CLR = '1;
    tick();
    CLR = '0;
    chk("e_cleared", 64'(ANY_PEND), 64'h0);
    START[0] = 1'b1; set_tc(0, 0);
    tick();
    START[0] = 1'b0; CLR[0] = 1'b1;
    tick();
    chk("e_pulse", 64'(PULSE[0]), 64'h1);
    chk("e_set_wins", 64'(PEND[0]), 64'h1);
    tick();
    CLR[0] = 1'b0;
    chk("e_clr", 64'(PEND[0]), 64'h0);
    chk("e_any", 64'(ANY_PEND), 64'h0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      RST_N = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < NCH; c++) begin
        START[c]    = ($urandom_range(0, 11) == 0);
        STOP[c]     = ($urandom_range(0, 39) == 0);
        CLR[c]      = ($urandom_range(0, 5) == 0);
        PERIODIC[c] = $urandom_range(0, 1);
        set_tc(c, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12));
      end
      tick();
    end
    RST_N = 1'b1; START = '0; STOP = '0; CLR = '0;

    // reset mid-count discards every pending expiry
    START = '1; PERIODIC = 4'b0101;
    for (int c = 0; c < NCH; c++) set_tc(c, 1000);
    tick();
    START = '0;
    repeat (50) tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("f_busy", 64'(BUSY), 64'h0);
    chk("f_pulse", 64'(PULSE), 64'h0);
    chk("f_pend", 64'(PEND), 64'h0);
    saw = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (PULSE != '0 || BUSY != '0) saw = 1'b1;
    end
    chk("f_quiet", 64'(saw), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
